// File: rtl/regfile_access_ctrl.sv
// Request/response front end for a word-organised register cell array.
// One request is in flight at a time: IDLE -> ACCESS -> (CAPTURE) -> RESP -> IDLE.
module regfile_access_ctrl #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [WIDTH-1:0]       req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_rdata,
  output logic                   rsp_err,
  output logic [DEPTH-1:0]       row_select,
  output logic                   cell_write,
  output logic                   cell_read,
  output logic [WIDTH-1:0]       cell_wdata,
  input  logic [DEPTH*WIDTH-1:0] cell_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic                in_range_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [WIDTH-1:0]    rsp_rdata_q;
  logic                rsp_err_q;
  logic [DEPTH-1:0]    row_select_q;
  logic                cell_write_q;
  logic                cell_read_q;
  logic [WIDTH-1:0]    cell_wdata_q;

  logic [DEPTH-1:0]    req_onehot;
  logic [WIDTH-1:0]    sel_word;

  // Decode only existing rows: an out-of-range address yields an all-zero
  // one-hot, and only the latched row's slice reaches the capture mux.
  always_comb begin
    req_onehot = '0;
    sel_word   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      req_onehot[k] = (req_addr == ADDR_W'(k));
      if (addr_q == ADDR_W'(k)) sel_word = cell_rdata[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      write_q      <= 1'b0;
      in_range_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      row_select_q <= '0;
      cell_write_q <= 1'b0;
      cell_read_q  <= 1'b0;
      cell_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            write_q     <= req_write;
            in_range_q  <= |req_onehot;
            req_ready_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            state_q     <= ACCESS;
            // Strobes are registered so they appear exactly during ACCESS.
            if (|req_onehot) begin
              row_select_q <= req_onehot;
              cell_write_q <= req_write;
              cell_read_q  <= !req_write;
              cell_wdata_q <= req_wdata;
            end
          end
        end
        ACCESS: begin
          row_select_q <= '0;
          cell_write_q <= 1'b0;
          cell_read_q  <= 1'b0;
          cell_wdata_q <= '0;
          if (!in_range_q) begin
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (write_q) begin
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_rdata_q <= sel_word;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign row_select = row_select_q;
  assign cell_write = cell_write_q;
  assign cell_read  = cell_read_q;
  assign cell_wdata = cell_wdata_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: an 8-row instance backed by a cell-array
// model, plus a 6-row instance exercising out-of-range addresses.
module tb_regfile_access_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // 8-row instance
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [7:0]  row_select;
  logic        cell_write, cell_read;
  logic [7:0]  cell_wdata;
  logic [63:0] cell_rdata;

  // 6-row instance
  logic        req_valid6, req_ready6, req_write6;
  logic [2:0]  req_addr6;
  logic [7:0]  req_wdata6;
  logic        rsp_valid6, rsp_ready6, rsp_err6;
  logic [7:0]  rsp_rdata6;
  logic [5:0]  row_select6;
  logic        cell_write6, cell_read6;
  logic [7:0]  cell_wdata6;
  logic [47:0] cell_rdata6;

  regfile_access_ctrl #(.DEPTH(8), .WIDTH(8), .ADDR_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .row_select(row_select), .cell_write(cell_write), .cell_read(cell_read),
    .cell_wdata(cell_wdata), .cell_rdata(cell_rdata)
  );

  regfile_access_ctrl #(.DEPTH(6), .WIDTH(8), .ADDR_W(3)) dut6 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid6), .req_ready(req_ready6), .req_write(req_write6),
    .req_addr(req_addr6), .req_wdata(req_wdata6),
    .rsp_valid(rsp_valid6), .rsp_ready(rsp_ready6), .rsp_rdata(rsp_rdata6), .rsp_err(rsp_err6),
    .row_select(row_select6), .cell_write(cell_write6), .cell_read(cell_read6),
    .cell_wdata(cell_wdata6), .cell_rdata(cell_rdata6)
  );

  // Cell array: writes on strobe, out_data register loads only on a read strobe,
  // so unread rows hold stale garbage that must never reach rsp_rdata.
  logic [7:0] cell_mem [8] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
  logic [7:0] cell_out [8] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7};

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (cell_write && row_select[k]) cell_mem[k] <= cell_wdata;
      if (cell_read && row_select[k])  cell_out[k] <= cell_mem[k];
    end
  end

  always_comb begin
    cell_rdata = '0;
    for (int k = 0; k < 8; k++) cell_rdata[k*8 +: 8] = cell_out[k];
  end

  assign cell_rdata6 = {6{8'h5A}};

  // Scoreboard state
  logic [7:0] model_mem [8];
  logic [8:0] exp_q [$];
  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: pops the expected {err, rdata} on each handshake.
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", 32'(rsp_err), 32'(e[8]));
        check("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
      end
    end
  end

  // Drive one request through the 8-row instance and walk it cycle by cycle.
  task automatic do_req(input logic wr, input logic [2:0] addr, input logic [7:0] wd, input int hold);
    int n;
    logic [7:0] exp_rd;
    logic [7:0] oh;
    exp_rd = wr ? 8'h00 : model_mem[addr];
    if (wr) model_mem[addr] = wd;
    oh = 8'd1 << addr;
    exp_q.push_back({1'b0, exp_rd});
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(n < 50), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk); #1;
    // Garbage on req_* after acceptance must be ignored.
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 3'($urandom);
    req_wdata = 8'($urandom);
    check("acc_row_select", 32'(row_select), 32'(oh));
    check("acc_cell_write", 32'(cell_write), 32'(wr));
    check("acc_cell_read", 32'(cell_read), 32'(!wr));
    check("acc_cell_wdata", 32'(cell_wdata), 32'(wd));
    check("acc_rsp_valid", 32'(rsp_valid), 32'd0);
    check("acc_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    if (!wr) begin
      check("cap_rsp_valid", 32'(rsp_valid), 32'd0);
      check("cap_strobes", 32'({row_select, cell_read, cell_write}), 32'd0);
      @(posedge clk); #1;
    end
    check("resp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("resp_strobes", 32'({row_select, cell_read, cell_write, cell_wdata}), 32'd0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 3'($urandom);
      @(posedge clk); #1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
      check("hold_rsp_err", 32'(rsp_err), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_row_select", 32'(row_select), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_row_select"}, 32'(row_select), 32'd0);
    check({tag, "_strobes"}, 32'({cell_write, cell_read}), 32'd0);
    check({tag, "_cell_wdata"}, 32'(cell_wdata), 32'd0);
  endtask

  initial begin
    logic [2:0] oor_addr [2];
    logic       oor_wr [2];
    int n;
    for (int k = 0; k < 8; k++) model_mem[k] = 8'hC0 + 8'(k);
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid6 = 1'b0; req_write6 = 1'b0; req_addr6 = '0; req_wdata6 = '0; rsp_ready6 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_req_ready6", 32'(req_ready6), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    do_req(1'b1, 3'd5, 8'hA5, 0);
    do_req(1'b0, 3'd5, 8'h00, 0);
    do_req(1'b0, 3'd5, 8'h3C, 5);
    do_req(1'b1, 3'd0, 8'h11, 0);
    do_req(1'b1, 3'd7, 8'h77, 0);
    do_req(1'b0, 3'd0, 8'h00, 0);
    do_req(1'b0, 3'd7, 8'h00, 0);
    repeat (12) do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       8'($urandom_range(0, 255)), $urandom_range(0, 2));

    // Abort a read while it sits in CAPTURE.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd5; req_wdata = 8'h00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    do_req(1'b0, 3'd5, 8'h00, 0);

    // Out-of-range requests on the 6-row instance.
    oor_addr[0] = 3'd7; oor_wr[0] = 1'b0;
    oor_addr[1] = 3'd6; oor_wr[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      n = 0;
      while (!req_ready6 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("oor_ready_wait", 32'(n < 50), 32'd1);
      req_valid6 = 1'b1; req_write6 = oor_wr[t]; req_addr6 = oor_addr[t]; req_wdata6 = 8'hFF;
      @(posedge clk); #1;
      req_valid6 = 1'b0;
      check("oor_acc_select", 32'({row_select6, cell_write6, cell_read6}), 32'd0);
      check("oor_acc_wdata", 32'(cell_wdata6), 32'd0);
      check("oor_acc_rsp_valid", 32'(rsp_valid6), 32'd0);
      @(posedge clk); #1;
      check("oor_rsp_valid", 32'(rsp_valid6), 32'd1);
      check("oor_rsp_err", 32'(rsp_err6), 32'd1);
      check("oor_rsp_rdata", 32'(rsp_rdata6), 32'd0);
      check("oor_resp_select", 32'({row_select6, cell_write6, cell_read6}), 32'd0);
      @(posedge clk); #1;
      check("oor_idle_valid", 32'(rsp_valid6), 32'd0);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 8, number of register words (rows of memory cells)
- WIDTH, 8, bits per word
- ADDR_W, 3, request address width; 2**ADDR_W >= DEPTH
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  address >= DEPTH
- row_select  out  DEPTH  one-hot word select to cell array
- cell_write  out  1  write strobe to all cells
- cell_read  out  1  read strobe to all cells
- cell_wdata  out  WIDTH  data to cell in_data pins
- cell_rdata  in  DEPTH*WIDTH  flattened cell out_data; word k at bits [k*WIDTH +: WIDTH]
REQ-003 Reset SHALL be reset_n, asynchronous, active-low; clock SHALL be clk.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, ACCESS, CAPTURE, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-006 On acceptance, addr, write flag and wdata SHALL be latched; the FSM SHALL go IDLE->ACCESS.
REQ-007 In ACCESS with latched addr < DEPTH: row_select = one-hot(addr), cell_write = write flag, cell_read = not write flag, cell_wdata = latched wdata.
REQ-008 In every state other than ACCESS, row_select, cell_write and cell_read SHALL be 0; cell_wdata SHALL be 0 outside ACCESS.
REQ-009 ACCESS SHALL last exactly one cycle: write -> RESP; read -> CAPTURE; out-of-range -> RESP.
REQ-010 Out-of-range addr (>= DEPTH) SHALL assert no select, read or write; the response SHALL carry rsp_err=1 and rsp_rdata=0.
REQ-011 In CAPTURE (one cycle), rsp_rdata SHALL be loaded at the exiting edge from cell_rdata slice [addr*WIDTH +: WIDTH]; next state RESP.
REQ-012 For writes, rsp_rdata SHALL be 0 and rsp_err 0.
REQ-013 rsp_valid SHALL be 1 only in RESP; rsp_rdata and rsp_err SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-014 RESP->IDLE SHALL occur on the edge where rsp_ready=1; there is no acceptance in that same edge.
REQ-015 Latency from acceptance edge to first rsp_valid cycle: write 2 edges, read 3 edges, error 2 edges; throughput at most one request per 3 (write) or 4 (read) cycles with rsp_ready held 1.
REQ-016 Only one request SHALL be outstanding; req_* inputs outside the acceptance edge SHALL be ignored.
REQ-017 X on cell_rdata of unselected rows SHALL NOT propagate; only the latched-address slice is sampled.

Reset
REQ-018 While reset_n=0: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, row_select=0, cell_write=0, cell_read=0, cell_wdata=0, latched registers 0.
REQ-019 Reset asserted mid-operation SHALL abort the transaction immediately with no response; strobes drop asynchronously.
REQ-020 After reset release, the first rising edge with req_valid=1 SHALL be accepted.

Verification
REQ-021 Write addr 5, data 0xA5 -> one ACCESS cycle with row_select=0x20, cell_write=1, cell_wdata=0xA5; rsp_valid 2 edges later, rsp_err=0, rsp_rdata=0.
REQ-022 Read addr 5 after REQ-021 -> ACCESS with row_select=0x20, cell_read=1; rsp_valid 3 edges after acceptance, rsp_rdata=0xA5.
REQ-023 DEPTH=6, ADDR_W=3, read addr 7 -> no select or strobe in any cycle; rsp_err=1, rsp_rdata=0 after 2 edges.
REQ-024 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, second pending req_valid not accepted until the edge after rsp_ready=1.
REQ-025 reset_n pulled low during CAPTURE of a read -> all outputs at reset values within the same cycle; no rsp_valid; next request is served normally.
REQ-026 Back-to-back writes addr 0 data 0x11 then addr 7 data 0x77 with rsp_ready=1, then reads of both -> rsp_rdata 0x11 and 0x77 respectively.
